pri_arb_rr: RTL and testbench
=============================

Name: pri_arb_rr

Overview:
Parametrised N-request priority arbiter. It generalises the team's 4:2 priority encoder into a registered, handshaked block with a selectable fixed-priority or round-robin mode. It samples a request vector, latches a winner, and holds the grant (index plus one-hot) until the consumer accepts it. It sits between request sources (DMA channels, bus masters) and a single shared resource.

Parameters:
N, 8, number of request lines; N >= 2; N need not be a power of two.
W, $clog2(N), width of the grant index; derived, do not override.
MODE, 0, 0 = fixed priority (highest index wins); 1 = round-robin.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous, active-high reset.
req  input  N  request vector; bit i = requester i.
gnt_ready  input  1  consumer accepts the current grant this cycle.
gnt_valid  output  1  grant outputs are valid.
gnt_idx  output  W  index of the granted requester.
gnt_onehot  output  N  one-hot form of gnt_idx; all zero when gnt_valid = 0.

Behaviour:
- Reset, sampled on the clk edge with rst = 1:
  - gnt_valid = 0, gnt_idx = 0, gnt_onehot = 0.
  - Pointer ptr = N-1; state = IDLE.
  - rst overrides all other inputs.
  - Reset mid-grant drops the grant and does not count as an accept.
- States: IDLE (no grant held) and GRANT (gnt_valid = 1).
- Arbitration function, combinational on the current req:
  - MODE 0: winner = highest set bit of req.
  - MODE 1: search descending from ptr (ptr, ptr-1, …, 0, N-1, …, ptr+1); the first set bit wins.
  - Because ptr resets to N-1, the first MODE 1 grant equals the MODE 0 result.
- IDLE:
  - If req != 0, load the winner into gnt_idx/gnt_onehot, set gnt_valid, go to GRANT.
  - Latency: req sampled at edge k produces gnt_valid = 1 after edge k.
  - If req == 0, stay in IDLE with outputs zero.
- GRANT with gnt_ready = 0: gnt_idx, gnt_onehot and gnt_valid hold stable. This holds even if req changes or the granted bit deasserts; no preemption.
- GRANT with gnt_ready = 1 (transfer):
  - MODE 1: ptr updates to (gnt_idx - 1) mod N; gnt_idx = 0 gives ptr = N-1.
  - MODE 0: ptr is unused.
  - In the same cycle, arbitrate the current req using the updated ptr:
    - req != 0: load the new winner and keep gnt_valid = 1, giving back-to-back grants with no bubble.
    - req == 0: clear gnt_valid and gnt_onehot, hold gnt_idx at its last value, go to IDLE.
- gnt_ready while in IDLE is ignored.
- MODE 0 may starve low indices; this is by design. MODE 1 guarantees each persistent requester a grant within N accepts.
- All index arithmetic is modulo N, including wrap for non-power-of-two N.
- Outputs are registered only; no combinational path from req or gnt_ready to any output.

Test Plan:
1. MODE 0, N = 4: req = 0011, gnt_ready = 1 held → one cycle later gnt_valid = 1, gnt_idx = 1, gnt_onehot = 0010; stays at idx 1 every cycle.
2. MODE 1, N = 4: req = 1111 steady, gnt_ready = 1 → gnt_idx sequence 3, 2, 1, 0, 3, 2, with gnt_valid continuously 1.
3. Hold: MODE 1, N = 4, grant idx = 2 with gnt_ready = 0; change req to 1000 for 5 cycles → idx stays 2 and onehot stays 0100. Pulse gnt_ready → next grant idx = 3.
4. Empty and latch: req = 0000 → gnt_valid stays 0. One-cycle pulse req = 0001 in IDLE → gnt_valid = 1, idx = 0, held after req drops. Accept with req = 0 → gnt_valid = 0, gnt_onehot = 0.
5. Reset mid-operation: MODE 1, N = 4, req = 1111, after grants 3 and 2, assert rst for one edge → gnt_valid = 0. Release → first grant is idx 3 (ptr restored).
6. Non-power-of-two wrap: MODE 1, N = 5, req = 10001, gnt_ready = 1 → gnt_idx alternates 4, 0, 4, 0; W = 3.

Source files
------------

// File: rtl/pri_arb_rr_if.sv
// pri_arb_rr_if: request/grant handshake bundle for the N-way arbiter.
// Ports: req[N], gnt_ready in toward the arbiter; gnt_valid, gnt_idx[W], gnt_onehot[N] out.
// slave = arbiter side, master = request source / grant consumer side.
interface pri_arb_rr_if #(
  parameter int N = 8
);
  localparam int W = $clog2(N);

  logic [N-1:0] req;
  logic         gnt_ready;
  logic         gnt_valid;
  logic [W-1:0] gnt_idx;
  logic [N-1:0] gnt_onehot;

  modport master (
    output req, gnt_ready,
    input  gnt_valid, gnt_idx, gnt_onehot
  );

  modport slave (
    input  req, gnt_ready,
    output gnt_valid, gnt_idx, gnt_onehot
  );
endinterface

// File: rtl/pri_arb_rr.sv
// pri_arb_rr: registered N-way arbiter, fixed priority (MODE 0, highest index wins)
// or round-robin (MODE 1). Grant appears one edge after req is seen in IDLE and is
// held unchanged until gnt_ready; an accept re-arbitrates in the same cycle (no bubble).
// Ports: clk, rst (sync, active-high), bus (pri_arb_rr_if.slave: req, gnt_ready in;
// gnt_valid, gnt_idx, gnt_onehot out, all registered).
module pri_arb_rr #(
  parameter int N    = 8,
  parameter int MODE = 0
) (
  input  logic          clk,
  input  logic          rst,
  pri_arb_rr_if.slave   bus
);
  localparam int W = $clog2(N);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [0:0]   state;
  logic [W-1:0] ptr;
  logic         valid_q;
  logic [W-1:0] idx_q;
  logic [N-1:0] oh_q;

  logic         xfer;
  logic [W-1:0] ptr_dec;
  logic [W-1:0] arb_ptr;
  logic         win_found;
  logic [W-1:0] win_idx;
  logic [N-1:0] win_oh;

  assign xfer    = (state == GRANT) && bus.gnt_ready;

  // Pointer moves to one below the accepted index so that index gets lowest
  // priority next time; explicit wrap keeps non-power-of-two N correct.
  assign ptr_dec = (idx_q == '0) ? LAST : idx_q - 1'b1;

  // Fixed priority is a descending search that always starts at N-1. On an
  // accept the search must already use the post-accept pointer.
  assign arb_ptr = (MODE == 0) ? LAST : (xfer ? ptr_dec : ptr);

  // Descending circular search: arb_ptr, arb_ptr-1, ..., 0, N-1, ..., arb_ptr+1.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_oh    = '0;
    for (int k = 0; k < N; k++) begin
      if (!win_found && bus.req[(int'(arb_ptr) + N - k) % N]) begin
        win_found = 1'b1;
        win_idx   = W'((int'(arb_ptr) + N - k) % N);
      end
    end
    if (win_found) begin
      win_oh[win_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= LAST;
      valid_q <= 1'b0;
      idx_q   <= '0;
      oh_q    <= '0;
    end else if (state == IDLE) begin
      // gnt_ready is meaningless here; only a non-empty req moves us on.
      if (win_found) begin
        state   <= GRANT;
        valid_q <= 1'b1;
        idx_q   <= win_idx;
        oh_q    <= win_oh;
      end
    end else if (bus.gnt_ready) begin
      if (MODE != 0) begin
        ptr <= ptr_dec;
      end
      if (win_found) begin
        idx_q <= win_idx;
        oh_q  <= win_oh;
      end else begin
        // idx is left at the last granted value on purpose.
        state   <= IDLE;
        valid_q <= 1'b0;
        oh_q    <= '0;
      end
    end
    // GRANT without gnt_ready: everything holds, regardless of req.
  end

  assign bus.gnt_valid  = valid_q;
  assign bus.gnt_idx    = idx_q;
  assign bus.gnt_onehot = oh_q;
endmodule

// File: tb/tb_pri_arb_rr.sv
// tb_pri_arb_rr: scoreboard bench for pri_arb_rr in three configurations:
// dut 0 = MODE 0 / N 4, dut 1 = MODE 1 / N 4, dut 2 = MODE 1 / N 5.
// Inputs change on the falling edge; outputs are sampled on the falling edge after.
module tb_pri_arb_rr;
  logic clk = 1'b0;
  logic rst0, rst1, rst2;

  always #5 clk = ~clk;

  pri_arb_rr_if #(.N(4)) if0 ();
  pri_arb_rr_if #(.N(4)) if1 ();
  pri_arb_rr_if #(.N(5)) if2 ();

  pri_arb_rr #(.N(4), .MODE(0)) u_fp4 (.clk(clk), .rst(rst0), .bus(if0));
  pri_arb_rr #(.N(4), .MODE(1)) u_rr4 (.clk(clk), .rst(rst1), .bus(if1));
  pri_arb_rr #(.N(5), .MODE(1)) u_rr5 (.clk(clk), .rst(rst2), .bus(if2));

  typedef struct {
    logic [12:0] val;   // {valid, idx[3:0], onehot[7:0]}
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model state for the randomized scenario.
  int   nd[3] = '{4, 4, 5};
  int   md[3] = '{0, 1, 1};
  logic m_valid[3];
  int   m_idx[3];
  int   m_ptr[3];

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [12:0] pk(logic v, int idx);
    logic [7:0] oh;
    oh = v ? (8'd1 << idx) : 8'd0;
    return {v, 4'(idx), oh};
  endfunction

  function automatic logic [12:0] obs(int d);
    case (d)
      0:       return {if0.gnt_valid, 4'(if0.gnt_idx), 8'(if0.gnt_onehot)};
      1:       return {if1.gnt_valid, 4'(if1.gnt_idx), 8'(if1.gnt_onehot)};
      default: return {if2.gnt_valid, 4'(if2.gnt_idx), 8'(if2.gnt_onehot)};
    endcase
  endfunction

  task automatic drive(int d, logic [7:0] r, logic rdy);
    case (d)
      0:       begin if0.req = r[3:0]; if0.gnt_ready = rdy; end
      1:       begin if1.req = r[3:0]; if1.gnt_ready = rdy; end
      default: begin if2.req = r[4:0]; if2.gnt_ready = rdy; end
    endcase
  endtask

  task automatic set_rst(int d, logic v);
    case (d)
      0:       rst0 = v;
      1:       rst1 = v;
      default: rst2 = v;
    endcase
  endtask

  // Put one DUT through a clean reset edge and leave it idle with req = 0.
  task automatic do_reset(int d);
    drive(d, 8'h00, 1'b0);
    set_rst(d, 1'b1);
    tick();
    set_rst(d, 1'b0);
    m_valid[d] = 1'b0;
    m_idx[d]   = 0;
    m_ptr[d]   = nd[d] - 1;
  endtask

  function automatic int model_search(int d, logic [7:0] r, int p);
    int start;
    int j;
    start = (md[d] != 0) ? p : nd[d] - 1;
    for (int k = 0; k < nd[d]; k++) begin
      j = start - k;
      if (j < 0) j = j + nd[d];
      if (r[j]) return j;
    end
    return 0;
  endfunction

  function automatic logic [12:0] model_step(int d, logic [7:0] r, logic rdy);
    if (!m_valid[d]) begin
      if (r != 8'h00) begin
        m_idx[d]   = model_search(d, r, m_ptr[d]);
        m_valid[d] = 1'b1;
      end
    end else if (rdy) begin
      if (md[d] != 0) m_ptr[d] = (m_idx[d] == 0) ? nd[d] - 1 : m_idx[d] - 1;
      if (r != 8'h00) m_idx[d] = model_search(d, r, m_ptr[d]);
      else            m_valid[d] = 1'b0;
    end
    return pk(m_valid[d], m_idx[d]);
  endfunction

  task automatic test_reset();
    exp_t e;
    logic [12:0] o;
    // Requests and ready are active while rst is high: reset must win.
    for (int d = 0; d < 3; d++) begin
      drive(d, 8'h1f, 1'b1);
      set_rst(d, 1'b1);
    end
    tick();
    for (int d = 0; d < 3; d++) sb.push_back('{pk(1'b0, 0), $sformatf("reset_dut%0d", d)});
    for (int d = 0; d < 3; d++) begin
      e = sb.pop_front();
      o = obs(d);
      n_checks++;
      if (o !== e.val)
        $display("FAIL %s: got v=%0b idx=%0d oh=%b, expected v=%0b idx=%0d oh=%b",
                 e.tag, o[12], o[11:8], o[7:0], e.val[12], e.val[11:8], e.val[7:0]);
      else n_pass++;
    end
  endtask

  task automatic test_fixed_priority();
    exp_t e;
    logic [12:0] o;
    logic [7:0] reqs[8] = '{8'h3, 8'h3, 8'h3, 8'h3, 8'hf, 8'hf, 8'h6, 8'h5};
    int         idxs[8] = '{1, 1, 1, 1, 3, 3, 2, 2};
    do_reset(0);
    for (int i = 0; i < 8; i++) begin
      drive(0, reqs[i], 1'b1);
      sb.push_back('{pk(1'b1, idxs[i]), $sformatf("fixed_pri_%0d", i)});
      tick();
      e = sb.pop_front();
      o = obs(0);
      n_checks++;
      if (o !== e.val)
        $display("FAIL %s: got v=%0b idx=%0d oh=%b, expected v=%0b idx=%0d oh=%b",
                 e.tag, o[12], o[11:8], o[7:0], e.val[12], e.val[11:8], e.val[7:0]);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [12:0] o;
    int seq[6] = '{3, 2, 1, 0, 3, 2};
    do_reset(1);
    for (int i = 0; i < 6; i++) begin
      drive(1, 8'hf, 1'b1);
      sb.push_back('{pk(1'b1, seq[i]), $sformatf("rr_b2b_%0d", i)});
      tick();
      e = sb.pop_front();
      o = obs(1);
      n_checks++;
      if (o !== e.val)
        $display("FAIL %s: got v=%0b idx=%0d oh=%b, expected v=%0b idx=%0d oh=%b",
                 e.tag, o[12], o[11:8], o[7:0], e.val[12], e.val[11:8], e.val[7:0]);
      else n_pass++;
    end
  endtask

  task automatic test_hold();
    exp_t e;
    logic [12:0] o;
    logic [7:0] reqs[9] = '{8'h4, 8'h8, 8'h8, 8'h8, 8'h8, 8'h8, 8'h8, 8'h8, 8'h0};
    logic       rdys[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    int         idxs[9] = '{2, 2, 2, 2, 2, 2, 3, 3, 3};
    do_reset(1);
    for (int i = 0; i < 9; i++) begin
      drive(1, reqs[i], rdys[i]);
      sb.push_back('{pk(1'b1, idxs[i]), $sformatf("hold_%0d", i)});
      tick();
      e = sb.pop_front();
      o = obs(1);
      n_checks++;
      if (o !== e.val)
        $display("FAIL %s: got v=%0b idx=%0d oh=%b, expected v=%0b idx=%0d oh=%b",
                 e.tag, o[12], o[11:8], o[7:0], e.val[12], e.val[11:8], e.val[7:0]);
      else n_pass++;
    end
  endtask

  task automatic test_empty_latch();
    exp_t e;
    logic [12:0] o;
    logic [7:0] reqs[11] = '{8'h0, 8'h0, 8'h1, 8'h0, 8'h0, 8'h0, 8'h4, 8'h0, 8'h0, 8'h0, 8'h2};
    logic       rdys[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic       vs[11]   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    int         idxs[11] = '{0, 0, 0, 0, 0, 0, 2, 2, 2, 2, 1};
    do_reset(0);
    for (int i = 0; i < 11; i++) begin
      drive(0, reqs[i], rdys[i]);
      sb.push_back('{pk(vs[i], idxs[i]), $sformatf("empty_latch_%0d", i)});
      tick();
      e = sb.pop_front();
      o = obs(0);
      n_checks++;
      if (o !== e.val)
        $display("FAIL %s: got v=%0b idx=%0d oh=%b, expected v=%0b idx=%0d oh=%b",
                 e.tag, o[12], o[11:8], o[7:0], e.val[12], e.val[11:8], e.val[7:0]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    logic [12:0] o;
    logic rsts[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic vs[5]   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    int   idxs[5] = '{3, 2, 0, 3, 2};
    do_reset(1);
    for (int i = 0; i < 5; i++) begin
      drive(1, 8'hf, 1'b1);
      set_rst(1, rsts[i]);
      sb.push_back('{pk(vs[i], idxs[i]), $sformatf("reset_mid_%0d", i)});
      tick();
      e = sb.pop_front();
      o = obs(1);
      n_checks++;
      if (o !== e.val)
        $display("FAIL %s: got v=%0b idx=%0d oh=%b, expected v=%0b idx=%0d oh=%b",
                 e.tag, o[12], o[11:8], o[7:0], e.val[12], e.val[11:8], e.val[7:0]);
      else n_pass++;
    end
    set_rst(1, 1'b0);
  endtask

  task automatic test_wrap_n5();
    exp_t e;
    logic [12:0] o;
    do_reset(2);
    for (int i = 0; i < 6; i++) begin
      drive(2, 8'h11, 1'b1);
      sb.push_back('{pk(1'b1, (i % 2 == 0) ? 4 : 0), $sformatf("wrap_n5_%0d", i)});
      tick();
      e = sb.pop_front();
      o = obs(2);
      n_checks++;
      if (o !== e.val)
        $display("FAIL %s: got v=%0b idx=%0d oh=%b, expected v=%0b idx=%0d oh=%b",
                 e.tag, o[12], o[11:8], o[7:0], e.val[12], e.val[11:8], e.val[7:0]);
      else n_pass++;
    end
  endtask

  task automatic test_random(int d);
    exp_t e;
    logic [12:0] o;
    logic [7:0] r;
    logic rdy;
    do_reset(d);
    for (int i = 0; i < 200; i++) begin
      r   = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, (1 << nd[d]) - 1));
      rdy = 1'($urandom_range(0, 1));
      drive(d, r, rdy);
      sb.push_back('{model_step(d, r, rdy), $sformatf("random_dut%0d_%0d", d, i)});
      tick();
      e = sb.pop_front();
      o = obs(d);
      n_checks++;
      if (o !== e.val)
        $display("FAIL %s: got v=%0b idx=%0d oh=%b, expected v=%0b idx=%0d oh=%b",
                 e.tag, o[12], o[11:8], o[7:0], e.val[12], e.val[11:8], e.val[7:0]);
      else n_pass++;
    end
  endtask

  initial begin
    rst0 = 1'b1;
    rst1 = 1'b1;
    rst2 = 1'b1;
    for (int d = 0; d < 3; d++) drive(d, 8'h00, 1'b0);
    @(negedge clk);
    test_reset();
    test_fixed_priority();
    test_back_to_back();
    test_hold();
    test_empty_latch();
    test_reset_mid();
    test_wrap_n5();
    for (int d = 0; d < 3; d++) test_random(d);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
